sid_write_scheduler: RTL and testbench

Timed register-write scheduler placed in front of the `sid` register bus. A host (debug port, tune player, test injector) queues commands of the form (delay, address, data). The scheduler replays each command as a SID register write after the programmed number of 1 MHz ticks, sharing the bus with the 6502. The CPU always has priority; a host write that collides with a CPU access is deferred to the next free 1 MHz strobe.

---
 rtl/sid_write_scheduler_if.sv | 42 ++++
 rtl/sid_write_scheduler.sv | 120 ++++++++++++
 tb/tb_sid_write_scheduler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sid_write_scheduler_if.sv
// Host command port, CPU-side SID bus and the muxed SID bus for the write scheduler.
// The scheduler sits on the slave modport; the host/CPU side drives the master modport.
interface sid_write_scheduler_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int DELAY_W    = 16
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               clk_1mhz_ph1_en;
  logic               i_cpu_cs;
  logic               i_cpu_we;
  logic [4:0]         i_cpu_addr;
  logic [7:0]         i_cpu_data;
  logic               i_enable;
  logic               i_flush;
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [DELAY_W-1:0] i_cmd_delay;
  logic [4:0]         i_cmd_addr;
  logic [7:0]         i_cmd_data;
  logic               o_sid_cs;
  logic               o_sid_we;
  logic [4:0]         o_sid_addr;
  logic [7:0]         o_sid_data;
  logic               o_busy;
  logic [LEVEL_W-1:0] o_level;
  logic [7:0]         o_defer_cnt;

  modport master (
    output clk_1mhz_ph1_en, i_cpu_cs, i_cpu_we, i_cpu_addr, i_cpu_data,
    output i_enable, i_flush, i_cmd_valid, i_cmd_delay, i_cmd_addr, i_cmd_data,
    input  o_cmd_ready, o_sid_cs, o_sid_we, o_sid_addr, o_sid_data,
    input  o_busy, o_level, o_defer_cnt
  );

  modport slave (
    input  clk_1mhz_ph1_en, i_cpu_cs, i_cpu_we, i_cpu_addr, i_cpu_data,
    input  i_enable, i_flush, i_cmd_valid, i_cmd_delay, i_cmd_addr, i_cmd_data,
    output o_cmd_ready, o_sid_cs, o_sid_we, o_sid_addr, o_sid_data,
    output o_busy, o_level, o_defer_cnt
  );
endinterface

// File: rtl/sid_write_scheduler.sv
// Replays queued (delay, addr, data) host commands as SID register writes on 1 MHz
// strobes, yielding the bus to the CPU and deferring host writes that collide with it.
module sid_write_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int DELAY_W    = 16
) (
  input logic                clk,
  input logic                rst,
  sid_write_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = DELAY_W + 13;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic [CW-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [LW-1:0]      level_reg;
  state_t             state_reg;
  state_t             state_next;
  logic [DELAY_W-1:0] cnt_reg;
  logic [DELAY_W-1:0] cnt_next;
  logic [4:0]         addr_reg;
  logic [7:0]         data_reg;
  logic [7:0]         defer_reg;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               host_issue;
  logic               defer;
  logic               strobe_run;

  assign full       = (level_reg == LW'(FIFO_DEPTH));
  assign empty      = (level_reg == '0);
  assign bus.o_cmd_ready = ~full & ~bus.i_flush & ~rst;
  assign push       = bus.i_cmd_valid & bus.o_cmd_ready;
  assign strobe_run = bus.clk_1mhz_ph1_en & bus.i_enable & ~bus.i_flush & ~rst;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    host_issue = 1'b0;
    defer      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Popping does not wait for a strobe, so a delay-0 successor still meets the next one.
        if (bus.i_enable & ~empty & ~bus.i_flush & ~rst) begin
          pop        = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (strobe_run) begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - DELAY_W'(1);
          end else if (~bus.i_cpu_cs) begin
            host_issue = 1'b1;
            state_next = ST_IDLE;
          end else begin
            defer = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (bus.i_flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  // Command storage: write port plus registered read into the command registers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.i_cmd_delay, bus.i_cmd_addr, bus.i_cmd_data};
    end
    if (pop) begin
      {cnt_reg, addr_reg, data_reg} <= mem[rd_ptr_reg];
    end else if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.i_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      level_reg <= level_reg + LW'(1);
      else if (pop && !push) level_reg <= level_reg - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      defer_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (defer && defer_reg != 8'hFF) defer_reg <= defer_reg + 8'd1;
    end
  end

  assign bus.o_sid_cs    = host_issue | bus.i_cpu_cs;
  assign bus.o_sid_we    = host_issue | bus.i_cpu_we;
  assign bus.o_sid_addr  = host_issue ? addr_reg : bus.i_cpu_addr;
  assign bus.o_sid_data  = host_issue ? data_reg : bus.i_cpu_data;
  assign bus.o_busy      = (state_reg == ST_WAIT);
  assign bus.o_level     = level_reg;
  assign bus.o_defer_cnt = defer_reg;
endmodule

// File: tb/tb_sid_write_scheduler.sv
// Directed bench for sid_write_scheduler: strobe every 4 clocks, host writes logged at negedge.
module tb_sid_write_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sid_write_scheduler_if #(.FIFO_DEPTH(16), .DELAY_W(16)) bus ();
  sid_write_scheduler #(.FIFO_DEPTH(16), .DELAY_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         s;
  } wr_t;

  wr_t log_q[$];
  int  checks = 0;
  int  errors = 0;
  int  phase  = 0;
  int  stb_n  = 0;
  int  s0, s1, n0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    bus.clk_1mhz_ph1_en = (phase == 3);
    if (phase == 3) stb_n++;
  endtask

  task automatic push_cmd(input logic [15:0] dl, input logic [4:0] a, input logic [7:0] d);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_delay = dl;
    bus.i_cmd_addr  = a;
    bus.i_cmd_data  = d;
    cyc();
    bus.i_cmd_valid = 1'b0;
  endtask

  // Returns the number of strobes that occurred before WAIT was entered.
  task automatic wait_busy(output int s);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.o_busy) break;
    end
    if (!bus.o_busy) chk("busy_timeout", 32'(bus.o_busy), 32'd1);
    s = stb_n - (bus.clk_1mhz_ph1_en ? 1 : 0);
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && log_q.size() < n; i++) cyc();
    chk("write_count", 32'(log_q.size()), 32'(n));
  endtask

  always @(negedge clk) begin
    if (rst !== 1'bx && bus.o_sid_cs && !bus.i_cpu_cs) begin
      log_q.push_back('{a: bus.o_sid_addr, d: bus.o_sid_data, s: stb_n});
      $display("host write addr=%02h data=%02h strobe=%0d", bus.o_sid_addr, bus.o_sid_data, stb_n);
      chk("wr_on_strobe", 32'(bus.clk_1mhz_ph1_en), 32'd1);
      chk("wr_we", 32'(bus.o_sid_we), 32'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.clk_1mhz_ph1_en = 1'b0;
    bus.i_cpu_cs = 1'b0;  bus.i_cpu_we = 1'b0;
    bus.i_cpu_addr = 5'h1F; bus.i_cpu_data = 8'hAA;
    bus.i_enable = 1'b1;  bus.i_flush = 1'b0;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_delay = '0;
    bus.i_cmd_addr = '0;  bus.i_cmd_data = '0;

    // Reset values and passthrough
    repeat (3) cyc();
    #1;
    chk("rst_ready", 32'(bus.o_cmd_ready), 32'd0);
    chk("rst_level", 32'(bus.o_level), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_defer", 32'(bus.o_defer_cnt), 32'd0);
    chk("rst_pass_addr", 32'(bus.o_sid_addr), 32'h1F);
    chk("rst_pass_data", 32'(bus.o_sid_data), 32'hAA);
    chk("rst_pass_cs", 32'(bus.o_sid_cs), 32'd0);
    rst = 1'b0;
    cyc();
    #1;
    chk("ready_after_rst", 32'(bus.o_cmd_ready), 32'd1);

    // Single delayed write: commit on 4th strobe of WAIT
    push_cmd(16'd3, 5'h04, 8'h41);
    wait_busy(s0);
    wait_writes(1, 60);
    chk("single_addr", 32'(log_q[0].a), 32'h04);
    chk("single_data", 32'(log_q[0].d), 32'h41);
    chk("single_strobe", 32'(log_q[0].s), 32'(s0 + 4));
    repeat (2) cyc();
    #1;
    chk("single_busy_fall", 32'(bus.o_busy), 32'd0);

    // Collision: CPU holds the bus on the two due strobes
    push_cmd(16'd0, 5'h18, 8'h0F);
    wait_busy(s0);
    bus.i_cpu_cs = 1'b1; bus.i_cpu_we = 1'b1;
    bus.i_cpu_addr = 5'h01; bus.i_cpu_data = 8'h55;
    for (int i = 0; i < 40; i++) begin
      if (stb_n == s0 + 2 && bus.clk_1mhz_ph1_en) break;
      cyc();
    end
    #1;
    chk("col_cpu_addr", 32'(bus.o_sid_addr), 32'h01);
    chk("col_cpu_data", 32'(bus.o_sid_data), 32'h55);
    chk("col_busy", 32'(bus.o_busy), 32'd1);
    cyc();
    bus.i_cpu_cs = 1'b0; bus.i_cpu_we = 1'b0;
    bus.i_cpu_addr = 5'h1F; bus.i_cpu_data = 8'hAA;
    wait_writes(2, 40);
    chk("col_addr", 32'(log_q[1].a), 32'h18);
    chk("col_data", 32'(log_q[1].d), 32'h0F);
    chk("col_strobe", 32'(log_q[1].s), 32'(s0 + 3));
    chk("col_defer", 32'(bus.o_defer_cnt), 32'd2);

    // Backpressure: 17 pushes while paused
    bus.i_enable = 1'b0;
    bus.i_cmd_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.i_cmd_delay = '0;
      bus.i_cmd_addr  = 5'(i);
      bus.i_cmd_data  = 8'(8'h80 + i);
      #1;
      chk(i < 16 ? "bp_ready" : "bp_full_ready", 32'(bus.o_cmd_ready), (i < 16) ? 32'd1 : 32'd0);
      cyc();
    end
    bus.i_cmd_valid = 1'b0;
    #1;
    chk("bp_level", 32'(bus.o_level), 32'd16);
    bus.i_enable = 1'b1;
    wait_writes(18, 400);
    for (int i = 0; i < 16; i++) begin
      chk("bp_addr", 32'(log_q[2 + i].a), 32'(i));
      chk("bp_data", 32'(log_q[2 + i].d), 32'(8'h80 + i));
      chk("bp_strobe", 32'(log_q[2 + i].s), 32'(log_q[2].s + i));
    end

    // Pause with cnt=5 for 100 strobes, then resume
    push_cmd(16'd5, 5'h0B, 8'h21);
    wait_busy(s0);
    bus.i_enable = 1'b0;
    n0 = log_q.size();
    repeat (400) cyc();
    chk("pause_nowrite", 32'(log_q.size()), 32'(n0));
    chk("pause_busy", 32'(bus.o_busy), 32'd1);
    bus.i_enable = 1'b1;
    s1 = stb_n - (bus.clk_1mhz_ph1_en ? 1 : 0);
    wait_writes(n0 + 1, 60);
    chk("pause_addr", 32'(log_q[n0].a), 32'h0B);
    chk("pause_data", 32'(log_q[n0].d), 32'h21);
    chk("pause_strobe", 32'(log_q[n0].s), 32'(s1 + 6));

    // Flush mid-WAIT with commands queued
    for (int i = 0; i < 5; i++) push_cmd(16'd10, 5'(5'h10 + i), 8'(8'hC0 + i));
    repeat (8) cyc();
    n0 = log_q.size();
    chk("fl_pre_busy", 32'(bus.o_busy), 32'd1);
    bus.i_flush = 1'b1;
    #1;
    chk("fl_ready_low", 32'(bus.o_cmd_ready), 32'd0);
    chk("fl_no_host", 32'(bus.o_sid_cs), 32'd0);
    cyc();
    bus.i_flush = 1'b0;
    #1;
    chk("fl_level", 32'(bus.o_level), 32'd0);
    chk("fl_busy", 32'(bus.o_busy), 32'd0);
    chk("fl_ready", 32'(bus.o_cmd_ready), 32'd1);
    chk("fl_defer_kept", 32'(bus.o_defer_cnt), 32'd2);
    repeat (200) cyc();
    chk("fl_nowrite", 32'(log_q.size()), 32'(n0));

    // Reset during a strobe with cnt=0 pending and 3 queued
    bus.i_enable = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(16'd0, 5'h1D, 8'(8'hE0 + i));
    bus.i_enable = 1'b1;
    wait_busy(s0);
    bus.i_enable = 1'b0;
    for (int i = 0; i < 8 && !bus.clk_1mhz_ph1_en; i++) cyc();
    chk("rs_level_pre", 32'(bus.o_level), 32'd3);
    n0 = log_q.size();
    rst = 1'b1;
    bus.i_enable = 1'b1;
    bus.i_cpu_addr = 5'h12; bus.i_cpu_data = 8'h34;
    #1;
    chk("rs_pass_addr", 32'(bus.o_sid_addr), 32'h12);
    chk("rs_pass_data", 32'(bus.o_sid_data), 32'h34);
    chk("rs_no_host_cs", 32'(bus.o_sid_cs), 32'd0);
    chk("rs_ready", 32'(bus.o_cmd_ready), 32'd0);
    cyc();
    #1;
    chk("rs_level", 32'(bus.o_level), 32'd0);
    chk("rs_busy", 32'(bus.o_busy), 32'd0);
    chk("rs_defer", 32'(bus.o_defer_cnt), 32'd0);
    rst = 1'b0;
    repeat (40) cyc();
    chk("rs_nowrite", 32'(log_q.size()), 32'(n0));
    chk("rs_level_post", 32'(bus.o_level), 32'd0);
    chk("rs_busy_post", 32'(bus.o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
